// File: rtl/cache_line_addr_gen.sv
// Line-to-word address sequencer: line index -> external x10 stage -> burst
// of WORDS consecutive word addresses on a valid/ready stream.
module cache_line_addr_gen #(
  parameter int IDX_W   = 16,
  parameter int ADDR_W  = 20,
  parameter int WORDS   = 10,
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [IDX_W-1:0]  req_idx,
  output logic [IDX_W-1:0]  mul_in,
  input  logic [ADDR_W-1:0] mul_out,
  output logic              addr_vld,
  input  logic              addr_rdy,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_last,
  output logic              busy
);

  localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_BURST
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IDX_W-1:0]  r_idx_q;
  logic [ADDR_W-1:0] r_base_q;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic [WCNT_W-1:0] r_wcnt;

  logic w_accept;
  logic w_wait_done;
  logic w_is_last;
  logic w_beat;

  assign w_accept    = req_rdy & req_vld;
  assign w_wait_done = (r_wcnt == WCNT_W'(MUL_LAT - 1));
  assign w_is_last   = (r_cnt == CNT_W'(WORDS - 1));
  assign w_beat      = addr_vld & addr_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_wait_done) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_next = S_BURST;
      end
      S_BURST: begin
        if (w_beat && w_is_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // mul_in stays on the last accepted index so the multiplier never sees X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx_q  <= '0;
      r_wcnt   <= '0;
      r_base_q <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx_q <= req_idx;
            r_wcnt  <= '0;
          end
        end
        S_WAIT: begin
          if (!w_wait_done) r_wcnt <= r_wcnt + WCNT_W'(1);
        end
        S_LOAD: begin
          r_base_q <= mul_out;
          r_cnt    <= '0;
          r_addr   <= mul_out;
        end
        S_BURST: begin
          if (w_beat && !w_is_last) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_addr <= r_base_q + ADDR_W'(r_cnt) + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // req_rdy is gated by rst so it is low for the whole reset assertion.
  always_comb begin
    req_rdy   = rst && (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    addr_vld  = (r_state == S_BURST);
    addr_last = (r_state == S_BURST) && w_is_last;
    addr      = r_addr;
    mul_in    = r_idx_q;
  end

endmodule
